// File: rtl/hazard_unit_if.sv
// Request bundle between the pipeline datapath and the hazard request generator.
// Vectors are indexed 4 = IF, 3 = ID, 2 = EX, 1 = MEM, 0 = WB.
interface hazard_unit_if;
  logic [4:0] valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] ex_rd;
  logic       ex_load;
  logic       ex_branch_taken;
  logic       ex_multi;
  logic [5:0] ex_cycles;
  logic       mem_access;
  logic       mem_ack;
  logic [4:0] stall;
  logic [4:0] flush;
  logic [4:0] extend;
  logic       mem_req;
  logic       pc_redirect;
  logic       ex_busy;

  modport master (
    output valid, id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_load,
           ex_branch_taken, ex_multi, ex_cycles, mem_access, mem_ack,
    input  stall, flush, extend, mem_req, pc_redirect, ex_busy
  );

  modport slave (
    input  valid, id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_load,
           ex_branch_taken, ex_multi, ex_cycles, mem_access, mem_ack,
    output stall, flush, extend, mem_req, pc_redirect, ex_busy
  );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush/extend request generator for the five-stage pipeline, including
// the multi-cycle EX sequencer and the data-memory wait handshake in MEM.
module hazard_unit (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  bus
);
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {EX_IDLE = 2'd0, EX_BUSY = 2'd1, EX_DONE = 2'd2} ex_state_t;
  typedef enum logic {MEM_IDLE = 1'b0, MEM_WAIT = 1'b1} mem_state_t;

  ex_state_t  ex_state, ex_state_n;
  mem_state_t mem_state, mem_state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic ex_start;
  logic ex_long;
  logic ex_extend;
  logic ex_adv;
  logic mem_extend;
  logic mem_req_c;
  logic load_use;
  logic redirect;
  logic unused_valid;

  assign unused_valid = ^{bus.valid[4], bus.valid[0]};

  assign ex_start = bus.valid[2] & bus.ex_multi;
  assign ex_long  = bus.ex_cycles >= CW'(2);
  assign ex_adv   = ~mem_extend;

  // State registers for both FSMs plus the EX cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_state  <= EX_IDLE;
      mem_state <= MEM_IDLE;
      cnt       <= '0;
    end else begin
      ex_state  <= ex_state_n;
      mem_state <= mem_state_n;
      cnt       <= cnt_n;
    end
  end

  // MEM handshake next state; a same-cycle ack never enters WAIT
  always_comb begin
    mem_state_n = mem_state;
    case (mem_state)
      MEM_IDLE: if (bus.valid[1] && bus.mem_access && !bus.mem_ack) mem_state_n = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ack) mem_state_n = MEM_IDLE;
      default:  mem_state_n = MEM_IDLE;
    endcase
  end

  // MEM handshake outputs
  always_comb begin
    mem_req_c  = 1'b0;
    mem_extend = 1'b0;
    case (mem_state)
      MEM_IDLE: begin
        if (bus.valid[1] && bus.mem_access) begin
          mem_req_c  = 1'b1;
          mem_extend = ~bus.mem_ack;
        end
      end
      MEM_WAIT: begin
        mem_req_c  = 1'b1;
        mem_extend = ~bus.mem_ack;
      end
      default: ;
    endcase
  end

  // EX sequencer next state; the counter runs even while MEM holds EX
  always_comb begin
    ex_state_n = ex_state;
    cnt_n      = cnt;
    case (ex_state)
      EX_IDLE: begin
        if (ex_start && ex_long) begin
          ex_state_n = EX_BUSY;
          cnt_n      = bus.ex_cycles - CW'(2);
        end
      end
      EX_BUSY: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (ex_adv) begin
          ex_state_n = EX_IDLE;
        end else begin
          ex_state_n = EX_DONE;
        end
      end
      EX_DONE: if (ex_adv) ex_state_n = EX_IDLE;
      default: ex_state_n = EX_IDLE;
    endcase
  end

  // EX sequencer outputs; DONE keeps the held instruction from restarting
  always_comb begin
    ex_extend = 1'b0;
    case (ex_state)
      EX_IDLE: ex_extend = ex_start & ex_long;
      EX_BUSY: ex_extend = (cnt != '0);
      default: ex_extend = 1'b0;
    endcase
  end

  assign load_use = bus.valid[3] & bus.valid[2] & bus.ex_load & (bus.ex_rd != '0) &
                    ((bus.id_use_rs & (bus.id_rs == bus.ex_rd)) |
                     (bus.id_use_rt & (bus.id_rt == bus.ex_rd)));

  assign redirect = bus.valid[2] & bus.ex_branch_taken & ~mem_extend & ~ex_extend;

  assign bus.stall       = {1'b0, load_use, 3'b000};
  assign bus.flush       = {1'b0, redirect, 3'b000};
  assign bus.extend      = {2'b00, ex_extend, mem_extend, 1'b0};
  assign bus.mem_req     = mem_req_c;
  assign bus.pc_redirect = redirect;
  assign bus.ex_busy     = (ex_state != EX_IDLE);
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: single-cycle vector table plus hand-written
// multi-cycle sequences for EX extend, MEM wait, DONE hold and async reset.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if bus ();

  hazard_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0] valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic       taken;
    logic       multi;
    logic [5:0] cycles;
    logic       mem_access;
    logic       mem_ack;
    logic [4:0] stall;
    logic [4:0] flush;
    logic [4:0] extend;
    logic       mem_req;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] s, input logic [4:0] f,
                         input logic [4:0] e, input logic mr, input logic busy);
    chk({tag, ".stall"},       32'(bus.stall),       32'(s));
    chk({tag, ".flush"},       32'(bus.flush),       32'(f));
    chk({tag, ".extend"},      32'(bus.extend),      32'(e));
    chk({tag, ".mem_req"},     32'(bus.mem_req),     32'(mr));
    chk({tag, ".pc_redirect"}, 32'(bus.pc_redirect), 32'(f[3]));
    chk({tag, ".ex_busy"},     32'(bus.ex_busy),     32'(busy));
  endtask

  task automatic clr();
    bus.valid = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 1'b0;
    bus.id_use_rt = 1'b0; bus.ex_rd = '0; bus.ex_load = 1'b0;
    bus.ex_branch_taken = 1'b0; bus.ex_multi = 1'b0; bus.ex_cycles = '0;
    bus.mem_access = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            valid     rs     rt     urs   urt   rd     load  tkn   mlt   cyc    macc  ack   stall     flush     extend    mreq
    vecs[0]  = '{5'b01100, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 5'b01000, 5'b00000, 5'b00000, 1'b0};
    vecs[1]  = '{5'b01100, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[2]  = '{5'b01100, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[3]  = '{5'b01100, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 5'b01000, 5'b00000, 5'b00000, 1'b0};
    vecs[4]  = '{5'b01000, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[5]  = '{5'b01100, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[6]  = '{5'b00100, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 5'b00000, 5'b01000, 5'b00000, 1'b0};
    vecs[7]  = '{5'b11000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[8]  = '{5'b00010, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1};
    vecs[9]  = '{5'b00001, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[10] = '{5'b00100, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[11] = '{5'b00100, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[12] = '{5'b01100, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 5'b01000, 5'b01000, 5'b00000, 1'b0};

    clr();
    rst = 1'b0;
    #3;
    chk_all("reset", 5'b0, 5'b0, 5'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;

    // Single-cycle table; every vector leaves both FSMs idle
    for (int i = 0; i < 13; i++) begin
      bus.valid = vecs[i].valid; bus.id_rs = vecs[i].id_rs; bus.id_rt = vecs[i].id_rt;
      bus.id_use_rs = vecs[i].use_rs; bus.id_use_rt = vecs[i].use_rt;
      bus.ex_rd = vecs[i].ex_rd; bus.ex_load = vecs[i].ex_load;
      bus.ex_branch_taken = vecs[i].taken; bus.ex_multi = vecs[i].multi;
      bus.ex_cycles = vecs[i].cycles; bus.mem_access = vecs[i].mem_access;
      bus.mem_ack = vecs[i].mem_ack;
      #3;
      chk_all($sformatf("vec%0d", i), vecs[i].stall, vecs[i].flush, vecs[i].extend,
              vecs[i].mem_req, 1'b0);
      tick();
    end
    clr();
    #3;
    chk_all("after_table", 5'b0, 5'b0, 5'b0, 1'b0, 1'b0);
    tick();

    // Multi-cycle EX, 4 cycles
    bus.valid = 5'b00100; bus.ex_multi = 1'b1; bus.ex_cycles = 6'd4;
    #3; chk_all("mc4_t0", 5'b0, 5'b0, 5'b00100, 1'b0, 1'b0); tick();
    #3; chk_all("mc4_t1", 5'b0, 5'b0, 5'b00100, 1'b0, 1'b1); tick();
    #3; chk_all("mc4_t2", 5'b0, 5'b0, 5'b00100, 1'b0, 1'b1); tick();
    #3; chk_all("mc4_t3", 5'b0, 5'b0, 5'b00000, 1'b0, 1'b1); tick();
    clr();
    #3; chk_all("mc4_t4", 5'b0, 5'b0, 5'b00000, 1'b0, 1'b0); tick();

    // MEM wait with ack two cycles late
    bus.valid = 5'b00010; bus.mem_access = 1'b1;
    #3; chk_all("mw_t0", 5'b0, 5'b0, 5'b00010, 1'b1, 1'b0); tick();
    #3; chk_all("mw_t1", 5'b0, 5'b0, 5'b00010, 1'b1, 1'b0); tick();
    bus.mem_ack = 1'b1;
    #3; chk_all("mw_t2", 5'b0, 5'b0, 5'b00000, 1'b1, 1'b0); tick();
    clr();
    #3; chk_all("mw_t3", 5'b0, 5'b0, 5'b00000, 1'b0, 1'b0); tick();

    // Taken branch held behind a MEM wait
    bus.valid = 5'b00110; bus.ex_branch_taken = 1'b1; bus.mem_access = 1'b1;
    #3; chk_all("br_t0", 5'b0, 5'b0, 5'b00010, 1'b1, 1'b0); tick();
    #3; chk_all("br_t1", 5'b0, 5'b0, 5'b00010, 1'b1, 1'b0); tick();
    bus.mem_ack = 1'b1;
    #3; chk_all("br_t2", 5'b0, 5'b01000, 5'b00000, 1'b1, 1'b0); tick();
    clr();
    #3; chk_all("br_t3", 5'b0, 5'b0, 5'b00000, 1'b0, 1'b0); tick();

    // 2-cycle EX op finishing while MEM still waits: parks in DONE
    bus.valid = 5'b00110; bus.ex_multi = 1'b1; bus.ex_cycles = 6'd2; bus.mem_access = 1'b1;
    #3; chk_all("dn_t0", 5'b0, 5'b0, 5'b00110, 1'b1, 1'b0); tick();
    #3; chk_all("dn_t1", 5'b0, 5'b0, 5'b00010, 1'b1, 1'b1); tick();
    #3; chk_all("dn_t2", 5'b0, 5'b0, 5'b00010, 1'b1, 1'b1); tick();
    bus.mem_ack = 1'b1;
    #3; chk_all("dn_t3", 5'b0, 5'b0, 5'b00000, 1'b1, 1'b1); tick();
    clr();
    #3; chk_all("dn_t4", 5'b0, 5'b0, 5'b00000, 1'b0, 1'b0); tick();

    // Async reset while BUSY with cnt = 3
    bus.valid = 5'b00100; bus.ex_multi = 1'b1; bus.ex_cycles = 6'd5;
    #3; chk_all("rs_t0", 5'b0, 5'b0, 5'b00100, 1'b0, 1'b0); tick();
    #1; chk_all("rs_t1", 5'b0, 5'b0, 5'b00100, 1'b0, 1'b1);
    clr();
    rst = 1'b0;
    #1; chk_all("rs_async", 5'b0, 5'b0, 5'b00000, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #3; chk_all("rs_rel0", 5'b0, 5'b0, 5'b00000, 1'b0, 1'b0); tick();
    #3; chk_all("rs_rel1", 5'b0, 5'b0, 5'b00000, 1'b0, 1'b0); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
